// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: producer latency classes, forwarding-select
// encodings and the default tracked-stage depth.
package cpu_pkg;

    localparam int NSTG_DEF = 3;

    // Slot index at which a producer's result first becomes forwardable.
    typedef enum logic [1:0] {
        LAT_NONE = 2'd0,
        LAT_ALU  = 2'd1,
        LAT_LOAD = 2'd2
    } lat_e;

    // fwd_sel value 0 reads the register file; value k selects slot k's result.
    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard handshake: operand/destination info in, stall/flush/forward
// controls and event counters out.
interface pipe_hazard_unit_if
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NSTG = NSTG_DEF,
    parameter int CW   = 16
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(NSTG);

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_rd;
    logic          id_wen;
    logic          id_is_load;
    logic          ex_redirect;

    logic          stall;
    logic          flush_ifid;
    logic          flush_idex;
    logic [SW:0]   fwd_rs_sel;
    logic [SW:0]   fwd_rt_sel;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wen, id_is_load, ex_redirect,
        input  stall, flush_ifid, flush_idex, fwd_rs_sel, fwd_rt_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wen, id_is_load, ex_redirect,
        output stall, flush_ifid, flush_idex, fwd_rs_sel, fwd_rt_sel,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Per-operand youngest-producer search over the tag pipeline; decides between
// forwarding from a slot and stalling until the producer's result is ready.
module hazard_match
    import cpu_pkg::*;
#(
    parameter int  NREG = 32,
    parameter int  NSTG = NSTG_DEF,
    localparam int AW   = $clog2(NREG),
    localparam int SW   = $clog2(NSTG)
) (
    input  logic [NSTG-1:0]         tag_vld,
    input  logic [NSTG-1:0][AW-1:0] tag_rd,
    input  logic [NSTG-1:0][1:0]    tag_lat,
    input  logic [AW-1:0]           src,
    input  logic                    used,
    output logic [SW:0]             sel,
    output logic                    stl
);

    logic hit;

    // Lowest slot index wins: once a match is seen, older slots are ignored.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        stl = 1'b0;
        for (int s = 0; s < NSTG; s++) begin
            if (!hit && used && (src != '0) && tag_vld[s] && (tag_rd[s] == src)) begin
                hit = 1'b1;
                if (s >= int'(tag_lat[s]))
                    sel = s[SW:0];
                else
                    stl = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destination tags after ID, drives
// operand forwarding selects, load/ALU-use stalls, redirect flushes and counters.
module pipe_hazard_unit
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NSTG = NSTG_DEF,
    parameter int CW   = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_unit_if.slave hz
);

    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(NSTG);

    logic [NSTG-1:0]         tag_vld_p;
    logic [NSTG-1:0][AW-1:0] tag_rd_p;
    logic [NSTG-1:0][1:0]    tag_lat_p;

    logic          rs_stall;
    logic          rt_stall;
    logic [SW:0]   rs_sel;
    logic [SW:0]   rt_sel;
    logic          stall_int;
    logic          redirect;
    logic          enter_vld;
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] flush_cnt_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    hazard_match #(.NREG(NREG), .NSTG(NSTG)) u_match_rs (
        .tag_vld (tag_vld_p),
        .tag_rd  (tag_rd_p),
        .tag_lat (tag_lat_p),
        .src     (hz.id_rs),
        .used    (hz.id_rs_used),
        .sel     (rs_sel),
        .stl     (rs_stall)
    );

    hazard_match #(.NREG(NREG), .NSTG(NSTG)) u_match_rt (
        .tag_vld (tag_vld_p),
        .tag_rd  (tag_rd_p),
        .tag_lat (tag_lat_p),
        .src     (hz.id_rt),
        .used    (hz.id_rt_used),
        .sel     (rt_sel),
        .stl     (rt_stall)
    );

    // Redirect outranks stall; reset gating keeps flushes quiet while held in reset.
    assign redirect  = hz.ex_redirect & reset;
    assign stall_int = (rs_stall | rt_stall) & hz.id_valid & ~hz.ex_redirect;
    assign enter_vld = hz.id_valid & hz.id_wen & (hz.id_rd != '0) & ~stall_int & ~hz.ex_redirect;

    // ID -> slot 0 boundary; each later slot takes the one before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tag_vld_p <= '0;
        else
            tag_vld_p <= {tag_vld_p[NSTG-2:0], enter_vld};
    end

    always_ff @(posedge clk) begin
        tag_rd_p  <= {tag_rd_p[NSTG-2:0], hz.id_rd};
        tag_lat_p <= {tag_lat_p[NSTG-2:0], (hz.id_is_load ? LAT_LOAD : LAT_ALU)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_int)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (hz.ex_redirect)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign hz.stall      = stall_int;
    assign hz.flush_ifid = redirect;
    assign hz.flush_idex = redirect | stall_int;
    assign hz.fwd_rs_sel = rs_sel;
    assign hz.fwd_rt_sel = rt_sel;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; register 0 is hard-wired zero.
REQ-002 SHALL have parameter NSTG, default 3: tracked stages after ID (slot 0=EX, 1=MEM, 2=WB); legal range 2..6.
REQ-003 SHALL have parameter CW, default 16: width of the statistics counters.
REQ-004 SHALL derive localparams AW = clog2(NREG) and SW = clog2(NSTG).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs, id_rt  in  AW each  source register numbers.
REQ-009 id_rs_used, id_rt_used  in  1 each  operand read in ID this cycle.
REQ-010 id_rd  in  AW  destination register.
REQ-011 id_wen  in  1  instruction writes id_rd.
REQ-012 id_is_load  in  1  result ready only at MEM/WB (slot 2).
REQ-013 ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-014 stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-015 flush_ifid, flush_idex  out  1 each  squash the respective pipeline register.
REQ-016 fwd_rs_sel, fwd_rt_sel  out  SW+1 each  0=register file, k=result register of slot k (1..NSTG-1).
REQ-017 stall_cnt, flush_cnt  out  CW each  saturating event counters.

Function
REQ-018 SHALL keep an NSTG-entry shift register of tags {valid, rd, lat}, where lat=1 for ALU and lat=2 for loads.
REQ-019 Each cycle SHALL shift tags slot i to slot i+1 and discard slot NSTG-1.
REQ-020 Slot 0 SHALL load {id_valid&id_wen&(id_rd!=0), id_rd, lat} only when stall=0 and ex_redirect=0; otherwise it SHALL load valid=0.
REQ-021 A match on an operand SHALL be a valid tag with rd equal to that operand, operand used, operand != 0.
REQ-022 Only the youngest match (lowest slot index) SHALL be considered.
REQ-023 A youngest match at slot s with s >= lat SHALL give fwd_sel=s.
REQ-024 A youngest match at slot s with s < lat SHALL raise a stall for that operand and give fwd_sel=0.
REQ-025 No match SHALL give fwd_sel=0.
REQ-026 stall SHALL equal (rs stall | rt stall) & id_valid & !ex_redirect.
REQ-027 ex_redirect SHALL assert flush_ifid=1 and flush_idex=1 in the same cycle; redirect beats stall.
REQ-028 flush_idex SHALL also be 1 whenever stall=1.
REQ-029 All outputs except counters SHALL be combinational from state and inputs, with zero latency.
REQ-030 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt SHALL increment on each cycle with ex_redirect=1.
REQ-031 Both counters SHALL saturate at 2^CW-1 and never wrap.
REQ-032 A load-use pair SHALL stall exactly 2 cycles when the consumer reads in ID; an ALU-use pair SHALL stall exactly 1 cycle.

Reset
REQ-033 reset low SHALL immediately clear all tag valids and both counters, regardless of clk.
REQ-034 While reset is low, stall, flush_ifid, flush_idex and both fwd_sel outputs SHALL read 0.
REQ-035 Deassertion mid-stall SHALL leave no residual stall; the first post-reset instruction sees an empty scoreboard.

Structure
REQ-036 The fwd_sel encodings, lat values (LAT_ALU=1, LAT_LOAD=2) and NSTG default SHALL live in shared package cpu_pkg.
REQ-037 The per-operand youngest-match and readiness logic SHALL be one sub-module, hazard_match, instantiated twice.

Verification
REQ-038 ALU hazard: add r5 then beq using r5 (rs_used) -> stall=1 for 1 cycle, then fwd_rs_sel=1, stall_cnt=1.
REQ-039 Load-use hazard: lw r7 then jr r7 -> stall=1 for 2 cycles, then fwd_rs_sel=2, stall_cnt=2.
REQ-040 Register zero: producer writes r0, consumer reads r0 -> stall=0, fwd_rs_sel=0.
REQ-041 Youngest wins: r3 written at slots 1 and 2 -> fwd_rt_sel=1.
REQ-042 Redirect over stall: ex_redirect=1 during load-use stall -> stall=0, both flushes=1, slot 0 invalid, flush_cnt=1.
REQ-043 Reset mid-stall and saturation: reset pulsed low mid-stall -> counters 0, stall 0 immediately; with CW=4, 20 stall cycles -> stall_cnt=15.
